multiword_adder_sequencer: RTL and testbench

Sequential front-end for the 2-bit `ripple_carry_adder`. It adds two WIDTH-bit operands by feeding the adder one 2-bit chunk per clock, LSB chunk first. The carry is held in a flip-flop between chunks, and the block reassembles the full sum. It sits directly upstream and downstream of the adder: it drives all five adder inputs and consumes `S0`, `S1` and `C2` on every cycle.

---
 rtl/multiword_adder_sequencer_if.sv | 36 +++
 rtl/multiword_adder_sequencer.sv | 88 ++++++++
 tb/tb_multiword_adder_sequencer.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/multiword_adder_sequencer_if.sv
// Operand/result handshake plus the per-chunk link to the 2-bit ripple adder.
// The slave modport faces the sequencer; the master side is the client and adder.
interface multiword_adder_sequencer_if #(
  parameter int WIDTH = 8
);
  logic             input_start;
  logic [WIDTH-1:0] input_A;
  logic [WIDTH-1:0] input_B;
  logic             input_Cin;
  logic             output_busy;
  logic             output_done;
  logic [WIDTH-1:0] output_S;
  logic             output_Cout;
  logic             output_A1;
  logic             output_B1;
  logic             output_A0;
  logic             output_B0;
  logic             output_C0;
  logic             input_S0;
  logic             input_S1;
  logic             input_C2;

  modport slave (
    input  input_start, input_A, input_B, input_Cin,
    input  input_S0, input_S1, input_C2,
    output output_busy, output_done, output_S, output_Cout,
    output output_A1, output_B1, output_A0, output_B0, output_C0
  );

  modport master (
    output input_start, input_A, input_B, input_Cin,
    output input_S0, input_S1, input_C2,
    input  output_busy, output_done, output_S, output_Cout,
    input  output_A1, output_B1, output_A0, output_B0, output_C0
  );
endinterface

// File: rtl/multiword_adder_sequencer.sv
// Adds two WIDTH-bit operands through an external 2-bit adder, one chunk per
// clock LSB first, carrying between chunks in a flop and reassembling the sum.
module multiword_adder_sequencer #(
  parameter int WIDTH = 8
) (
  input  logic                        clk,
  input  logic                        reset_n,
  multiword_adder_sequencer_if.slave  sif
);
  localparam int N  = WIDTH / 2;
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                state;
  logic [N-1:0][1:0]     a_reg, b_reg, partial, sum_next;
  logic                  carry_reg;
  logic [IW-1:0]         idx;
  logic                  busy_q, done_q, cout_q;
  logic [WIDTH-1:0]      s_q;
  logic                  run;

  assign run = (state == RUN);

  // Adder drive is gated so the adder sees all zeros outside RUN.
  assign sif.output_A1 = run & a_reg[idx][1];
  assign sif.output_A0 = run & a_reg[idx][0];
  assign sif.output_B1 = run & b_reg[idx][1];
  assign sif.output_B0 = run & b_reg[idx][0];
  assign sif.output_C0 = run & carry_reg;

  assign sif.output_busy = busy_q;
  assign sif.output_done = done_q;
  assign sif.output_S    = s_q;
  assign sif.output_Cout = cout_q;

  // Partial sum with the chunk currently leaving the adder merged in, so the
  // final edge can publish the complete result without an extra cycle.
  always_comb begin
    sum_next      = partial;
    sum_next[idx] = {sif.input_S1, sif.input_S0};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      a_reg     <= '0;
      b_reg     <= '0;
      partial   <= '0;
      carry_reg <= 1'b0;
      idx       <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      s_q       <= '0;
      cout_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (sif.input_start) begin
            a_reg     <= sif.input_A;
            b_reg     <= sif.input_B;
            carry_reg <= sif.input_Cin;
            idx       <= '0;
            partial   <= '0;
            busy_q    <= 1'b1;
            state     <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          partial   <= sum_next;
          carry_reg <= sif.input_C2;
          idx       <= idx + 1'b1;
          if (idx == IW'(N - 1)) begin
            s_q    <= sum_next;
            cout_q <= sif.input_C2;
            busy_q <= 1'b0;
            done_q <= 1'b1;
            state  <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_multiword_adder_sequencer.sv
// Closed-loop bench: behavioural 2-bit adders plus an arithmetic model of the
// sequencer, checked every cycle, with literal sums and a WIDTH=2 sweep.
module tb_multiword_adder_sequencer;
  localparam int W = 8;
  localparam int N = W / 2;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  multiword_adder_sequencer_if #(.WIDTH(W)) b8 ();
  multiword_adder_sequencer_if #(.WIDTH(2)) b2 ();

  multiword_adder_sequencer #(.WIDTH(W)) u8 (.clk(clk), .reset_n(reset_n), .sif(b8));
  multiword_adder_sequencer #(.WIDTH(2)) u2 (.clk(clk), .reset_n(reset_n), .sif(b2));

  // Behavioural ripple_carry_adder instances closing each loop.
  assign {b8.input_C2, b8.input_S1, b8.input_S0} =
    3'({b8.output_A1, b8.output_A0}) + 3'({b8.output_B1, b8.output_B0}) + 3'(b8.output_C0);
  assign {b2.input_C2, b2.input_S1, b2.input_S0} =
    3'({b2.output_A1, b2.output_A0}) + 3'({b2.output_B1, b2.output_B0}) + 3'(b2.output_C0);

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Model: operands captured on an accepted start, result due N edges later.
  logic [W-1:0] m_a = '0, m_b = '0, m_S = '0;
  logic         m_cin = 1'b0, m_busy = 1'b0, m_done = 1'b0, m_Cout = 1'b0;
  logic [W:0]   m_sum = '0;
  int           m_left = 0;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_busy <= 1'b0; m_done <= 1'b0; m_S <= '0; m_Cout <= 1'b0; m_left <= 0;
    end else begin
      m_done <= 1'b0;
      if (m_left > 0) begin
        m_left <= m_left - 1;
        if (m_left == 1) begin
          {m_Cout, m_S} <= m_sum;
          m_done <= 1'b1;
          m_busy <= 1'b0;
        end
      end else if (b8.input_start) begin
        m_a    <= b8.input_A;
        m_b    <= b8.input_B;
        m_cin  <= b8.input_Cin;
        m_sum  <= (W+1)'(b8.input_A) + (W+1)'(b8.input_B) + (W+1)'(b8.input_Cin);
        m_left <= N;
        m_busy <= 1'b1;
      end
    end
  end

  // Expected adder drive during RUN: chunk k of each operand, and the carry
  // into bit 2k of the true sum.
  function automatic logic [4:0] exp_drive(input int k);
    int mask, cy;
    mask = (1 << (2 * k)) - 1;
    cy   = ((int'(m_a) & mask) + (int'(m_b) & mask) + int'(m_cin)) >> (2 * k);
    return {m_a[2*k+1], m_b[2*k+1], m_a[2*k], m_b[2*k], cy[0]};
  endfunction

  always @(negedge clk) begin
    logic [4:0] drv;
    drv = {b8.output_A1, b8.output_B1, b8.output_A0, b8.output_B0, b8.output_C0};
    chk("busy", 32'(b8.output_busy), 32'(m_busy));
    chk("done", 32'(b8.output_done), 32'(m_done));
    chk("S", 32'(b8.output_S), 32'(m_S));
    chk("Cout", 32'(b8.output_Cout), 32'(m_Cout));
    if (m_busy) chk("drive_run", 32'(drv), 32'(exp_drive(N - m_left)));
    else        chk("drive_idle", 32'(drv), 32'd0);
  end

  task automatic rand_ops8();
    b8.input_A   = W'($urandom);
    b8.input_B   = W'($urandom);
    b8.input_Cin = 1'($urandom);
  endtask

  // Wait (bounded) for done; returns number of busy cycles seen before it.
  task automatic wait_done(output int busy_cycles, output logic seen);
    busy_cycles = 0;
    seen = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (b8.output_done) begin seen = 1'b1; break; end
      if (b8.output_busy) busy_cycles++;
    end
  endtask

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                        input logic [W:0] exp_sum, input string tag);
    int bc;
    logic seen;
    @(posedge clk); #1;
    b8.input_start = 1'b1; b8.input_A = a; b8.input_B = b; b8.input_Cin = cin;
    @(posedge clk); #1;
    b8.input_start = 1'b0;
    rand_ops8();
    wait_done(bc, seen);
    chk({tag, "_done_seen"}, 32'(seen), 32'd1);
    chk({tag, "_busy_cycles"}, 32'(bc), N);
    chk({tag, "_sum"}, 32'({b8.output_Cout, b8.output_S}), 32'(exp_sum));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int bc;
    logic seen;
    b8.input_start = 1'b0; b8.input_A = '0; b8.input_B = '0; b8.input_Cin = 1'b0;
    b2.input_start = 1'b0; b2.input_A = '0; b2.input_B = '0; b2.input_Cin = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_state", 32'({b8.output_busy, b8.output_done, b8.output_Cout, b8.output_S}), 32'd0);
    chk("reset_drive", 32'({b8.output_A1, b8.output_B1, b8.output_A0, b8.output_B0, b8.output_C0}), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    // Hand-computed sums.
    run_op(8'h5A, 8'h3C, 1'b0, 9'h096, "t5a3c");
    run_op(8'hFF, 8'h01, 1'b0, 9'h100, "tff01");
    run_op(8'hFF, 8'hFF, 1'b1, 9'h1FF, "tffff1");
    chk("model_pin", 32'(m_sum), 32'h1FF);

    // Start held through RUN with operands changing after capture.
    @(posedge clk); #1;
    b8.input_start = 1'b1; b8.input_A = 8'h12; b8.input_B = 8'h34; b8.input_Cin = 1'b1;
    @(posedge clk); #1;
    b8.input_A = 8'h11; b8.input_B = 8'h22; b8.input_Cin = 1'b0;
    wait_done(bc, seen);
    chk("held_done_seen", 32'(seen), 32'd1);
    chk("held_sum", 32'({b8.output_Cout, b8.output_S}), 32'h047);
    @(posedge clk); #1;
    b8.input_start = 1'b0;
    chk("held_restart_busy", 32'(b8.output_busy), 32'd1);
    wait_done(bc, seen);
    chk("held_second_sum", 32'({b8.output_Cout, b8.output_S}), 32'h033);

    // Reset two cycles into RUN.
    @(posedge clk); #1;
    b8.input_start = 1'b1; b8.input_A = 8'hC3; b8.input_B = 8'h5F; b8.input_Cin = 1'b1;
    @(posedge clk); #1;
    b8.input_start = 1'b0;
    @(posedge clk);
    @(posedge clk); #2;
    reset_n = 1'b0;
    #1;
    chk("abort_outputs", 32'({b8.output_busy, b8.output_done, b8.output_Cout, b8.output_S}), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    wait_done(bc, seen);
    chk("abort_no_done", 32'(seen), 32'd0);
    run_op(8'h80, 8'h80, 1'b1, 9'h101, "after_abort");

    // Randomized traffic, start pulses of varying length.
    for (int t = 0; t < 40; t++) begin
      int gap, len;
      gap = $urandom_range(0, 3);
      len = $urandom_range(1, 6);
      repeat (gap) @(posedge clk);
      for (int c = 0; c < len; c++) begin
        @(posedge clk); #1;
        b8.input_start = 1'b1;
        rand_ops8();
      end
      @(posedge clk); #1;
      b8.input_start = 1'b0;
      for (int c = 0; c < N + 2; c++) begin
        @(posedge clk); #1;
        rand_ops8();
      end
    end

    // Exhaustive WIDTH=2: v = {A1, B1, A0, B0, Cin}.
    for (int v = 0; v < 32; v++) begin
      logic [4:0] vv;
      logic [1:0] a2, b2v;
      vv  = 5'(v);
      a2  = {vv[4], vv[2]};
      b2v = {vv[3], vv[1]};
      @(posedge clk); #1;
      b2.input_start = 1'b1; b2.input_A = a2; b2.input_B = b2v; b2.input_Cin = vv[0];
      @(posedge clk); #1;
      b2.input_start = 1'b0;
      chk("w2_drive", 32'({b2.output_A1, b2.output_B1, b2.output_A0, b2.output_B0, b2.output_C0}), 32'(vv));
      chk("w2_busy", 32'(b2.output_busy), 32'd1);
      @(posedge clk); #1;
      chk("w2_done", 32'({b2.output_busy, b2.output_done}), 32'b01);
      chk("w2_sum", 32'({b2.output_Cout, b2.output_S}), 32'(a2) + 32'(b2v) + 32'(vv[0]));
      @(posedge clk); #1;
      chk("w2_idle_drive", 32'({b2.output_A1, b2.output_B1, b2.output_A0, b2.output_B0, b2.output_C0, b2.output_done}), 32'd0);
    end

    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
